// File: rtl/mem_align_splitter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_align_splitter_pkg
// Brief    : Shared load/store type encodings for the memory access path.
// Revision : 1.0 - initial release
// ============================================================================
package mem_align_splitter_pkg;

  localparam logic [2:0] c_LD_NONE = 3'd0;
  localparam logic [2:0] c_LD_LB   = 3'd1;
  localparam logic [2:0] c_LD_LH   = 3'd2;
  localparam logic [2:0] c_LD_LW   = 3'd3;
  localparam logic [2:0] c_LD_LBU  = 3'd4;
  localparam logic [2:0] c_LD_LHU  = 3'd5;

  localparam logic [1:0] c_ST_NONE = 2'd0;
  localparam logic [1:0] c_ST_SB   = 2'd1;
  localparam logic [1:0] c_ST_SH   = 2'd2;
  localparam logic [1:0] c_ST_SW   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mem_align_splitter_load_merge.sv
`default_nettype none
// ============================================================================
// Module   : load_merge
// Brief    : Combines two aligned words into the result of a misaligned load.
// Revision : 1.0 - initial release
// ============================================================================
module load_merge
  import mem_align_splitter_pkg::*;
(
  input  logic [31:0] i_lo,
  input  logic [31:0] i_hi,
  input  logic [1:0]  i_rem,
  input  logic [2:0]  i_type,
  output logic [31:0] o_data
);

  logic [31:0] w_win;

  assign w_win = 32'({i_hi, i_lo} >> {i_rem, 3'b000});

  always_comb begin
    o_data = w_win;
    case (i_type)
      c_LD_LH:  o_data = {{16{w_win[15]}}, w_win[15:0]};
      c_LD_LHU: o_data = {16'd0, w_win[15:0]};
      default:  o_data = w_win;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_align_splitter.sv
`default_nettype none
// ============================================================================
// Module   : mem_align_splitter
// Brief    : Splits misaligned stores into byte stores and misaligned loads
//            into two aligned word loads merged for writeback.
// Revision : 1.0 - initial release
// ============================================================================
module mem_align_splitter
  import mem_align_splitter_pkg::*;
(
  input  logic        clk,
  input  logic        rstd,
  input  logic [2:0]  info_load,
  input  logic [1:0]  info_store,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2,
  input  logic        write_reg,
  input  logic [4:0]  dst_addr,
  input  logic [31:0] load_data,
  output logic [2:0]  info_load_o,
  output logic [1:0]  info_store_o,
  output logic [31:0] alu_result_o,
  output logic [31:0] rs2_o,
  output logic        write_reg_o,
  output logic [4:0]  dst_addr_o,
  output logic        stall,
  output logic        merge_sel,
  output logic [31:0] merge_data
);

  localparam logic [1:0] c_S_IDLE   = 2'd0;
  localparam logic [1:0] c_S_ST_SEQ = 2'd1;
  localparam logic [1:0] c_S_LD_HI  = 2'd2;

  function automatic logic f_misaligned(input logic [2:0] ld, input logic [1:0] st,
                                        input logic [1:0] off);
    logic w_half, w_word;
    w_half = (st == c_ST_SH) || (ld == c_LD_LH) || (ld == c_LD_LHU);
    w_word = (st == c_ST_SW) || (ld == c_LD_LW);
    return (w_half && (off == 2'd3)) || (w_word && (off != 2'd0));
  endfunction

  logic [1:0]  r_state, w_next;
  logic [1:0]  r_cnt, r_last, r_rem;
  logic [31:0] r_addr, r_data, r_lo;
  logic [2:0]  r_ld;
  logic        r_wr;
  logic [4:0]  r_dst;
  logic        r_merge_sel;
  logic [31:0] r_merge_data;

  logic        w_is_st, w_mis, w_mis_st, w_mis_ld;
  logic [2:0]  w_ld_eff;
  logic [1:0]  w_last;
  logic [31:0] w_seq_addr, w_hi_addr, w_aligned, w_merged;
  logic [7:0]  w_seq_byte;

  // A store always wins over a simultaneous load; the load is dropped.
  assign w_is_st    = (info_store != c_ST_NONE);
  assign w_ld_eff   = w_is_st ? c_LD_NONE : info_load;
  assign w_mis      = f_misaligned(w_ld_eff, info_store, alu_result[1:0]);
  assign w_mis_st   = w_mis && w_is_st;
  assign w_mis_ld   = w_mis && !w_is_st;
  assign w_last     = (info_store == c_ST_SW) ? 2'd3 : 2'd1;
  assign w_aligned  = {alu_result[31:2], 2'b00};
  assign w_seq_addr = r_addr + {30'd0, r_cnt};
  assign w_seq_byte = 8'(r_data >> {r_cnt, 3'b000});
  assign w_hi_addr  = r_addr + 32'd4;

  load_merge u_load_merge (
    .i_lo   (r_lo),
    .i_hi   (load_data),
    .i_rem  (r_rem),
    .i_type (r_ld),
    .o_data (w_merged)
  );

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) r_state <= c_S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_S_IDLE: begin
        if (w_mis_st)      w_next = c_S_ST_SEQ;
        else if (w_mis_ld) w_next = c_S_LD_HI;
      end
      c_S_ST_SEQ: if (r_cnt == r_last) w_next = c_S_IDLE;
      c_S_LD_HI:  w_next = c_S_IDLE;
      default:    w_next = c_S_IDLE;
    endcase
  end

  always_comb begin
    info_load_o  = w_ld_eff;
    info_store_o = info_store;
    alu_result_o = alu_result;
    rs2_o        = rs2;
    write_reg_o  = write_reg;
    dst_addr_o   = dst_addr;
    stall        = 1'b0;
    case (r_state)
      c_S_IDLE: begin
        if (w_mis_st) begin
          info_store_o = c_ST_SB;
          rs2_o        = {24'd0, rs2[7:0]};
          write_reg_o  = 1'b0;
          stall        = 1'b1;
        end else if (w_mis_ld) begin
          info_load_o  = c_LD_LW;
          alu_result_o = w_aligned;
          write_reg_o  = 1'b0;
          stall        = 1'b1;
        end
      end
      c_S_ST_SEQ: begin
        info_load_o  = c_LD_NONE;
        info_store_o = c_ST_SB;
        alu_result_o = w_seq_addr;
        rs2_o        = {24'd0, w_seq_byte};
        write_reg_o  = 1'b0;
        dst_addr_o   = r_dst;
        stall        = (r_cnt != r_last);
      end
      c_S_LD_HI: begin
        info_load_o  = c_LD_LW;
        info_store_o = c_ST_NONE;
        alu_result_o = w_hi_addr;
        rs2_o        = 32'd0;
        write_reg_o  = r_wr;
        dst_addr_o   = r_dst;
      end
      default: ;
    endcase
    // Reset must silence the issue port even though it is combinational.
    if (!rstd) begin
      info_load_o  = c_LD_NONE;
      info_store_o = c_ST_NONE;
      write_reg_o  = 1'b0;
      stall        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      r_cnt        <= 2'd0;
      r_last       <= 2'd0;
      r_rem        <= 2'd0;
      r_addr       <= 32'd0;
      r_data       <= 32'd0;
      r_lo         <= 32'd0;
      r_ld         <= c_LD_NONE;
      r_wr         <= 1'b0;
      r_dst        <= 5'd0;
      r_merge_sel  <= 1'b0;
      r_merge_data <= 32'd0;
    end else begin
      r_merge_sel <= (r_state == c_S_LD_HI);
      if (r_state == c_S_LD_HI) r_merge_data <= w_merged;
      case (r_state)
        c_S_IDLE: begin
          if (w_mis_st) begin
            r_cnt  <= 2'd1;
            r_last <= w_last;
            r_addr <= alu_result;
            r_data <= rs2;
            r_dst  <= dst_addr;
          end else if (w_mis_ld) begin
            r_addr <= w_aligned;
            r_lo   <= load_data;
            r_rem  <= alu_result[1:0];
            r_ld   <= info_load;
            r_wr   <= write_reg;
            r_dst  <= dst_addr;
          end
        end
        c_S_ST_SEQ: r_cnt <= (r_cnt == r_last) ? 2'd0 : r_cnt + 2'd1;
        default: ;
      endcase
    end
  end

  assign merge_sel  = r_merge_sel;
  assign merge_data = r_merge_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_align_splitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_align_splitter
// Brief    : Scoreboard bench for mem_align_splitter with byte-level reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_align_splitter;
  import mem_align_splitter_pkg::*;

  logic        clk = 1'b0;
  logic        rstd = 1'b0;
  logic [2:0]  info_load = '0;
  logic [1:0]  info_store = '0;
  logic [31:0] alu_result = '0;
  logic [31:0] rs2 = '0;
  logic        write_reg = 1'b0;
  logic [4:0]  dst_addr = '0;
  logic [31:0] load_data;
  logic [2:0]  info_load_o;
  logic [1:0]  info_store_o;
  logic [31:0] alu_result_o, rs2_o, merge_data;
  logic        write_reg_o, stall, merge_sel;
  logic [4:0]  dst_addr_o;

  logic [31:0] ovr_a0 = 32'h1, ovr_d0 = '0, ovr_a1 = 32'h1, ovr_d1 = '0;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [2:0]  ld;
    logic [1:0]  st;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] mask;
    logic        wr;
    logic        chk_dst;
    logic [4:0]  dst;
    logic        stall;
    logic        is_hi;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mq[$];

  always #5 clk = ~clk;

  mem_align_splitter dut (
    .clk(clk), .rstd(rstd), .info_load(info_load), .info_store(info_store),
    .alu_result(alu_result), .rs2(rs2), .write_reg(write_reg), .dst_addr(dst_addr),
    .load_data(load_data), .info_load_o(info_load_o), .info_store_o(info_store_o),
    .alu_result_o(alu_result_o), .rs2_o(rs2_o), .write_reg_o(write_reg_o),
    .dst_addr_o(dst_addr_o), .stall(stall), .merge_sel(merge_sel), .merge_data(merge_data)
  );

  // Memory image: hashed contents with two overridable words.
  function automatic logic [31:0] word_at(input logic [31:0] a, input logic [31:0] a0,
      input logic [31:0] d0, input logic [31:0] a1, input logic [31:0] d1);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == a0) return d0;
    if (w == a1) return d1;
    return (w * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  assign load_data = word_at(alu_result_o, ovr_a0, ovr_d0, ovr_a1, ovr_d1);

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] w;
    w = word_at(a, ovr_a0, ovr_d0, ovr_a1, ovr_d1);
    return w[8*a[1:0] +: 8];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: an access that crosses a word boundary is split byte-wise.
  task automatic push_access(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] a,
                             input logic [31:0] d, input logic wr, input logic [4:0] dst);
    exp_t        e;
    int          sz;
    logic [2:0]  lde;
    logic [31:0] base, v;
    lde = (st != c_ST_NONE) ? c_LD_NONE : ld;
    if (st == c_ST_NONE && lde == c_LD_NONE) return;
    if (st != c_ST_NONE) sz = (st == c_ST_SB) ? 1 : (st == c_ST_SH) ? 2 : 4;
    else sz = (lde == c_LD_LW) ? 4 : (lde == c_LD_LH || lde == c_LD_LHU) ? 2 : 1;
    e = '0;
    if (int'(a[1:0]) + sz <= 4) begin
      e.ld = lde; e.st = st; e.addr = a; e.data = d; e.mask = '1;
      e.wr = wr; e.chk_dst = 1'b1; e.dst = dst; e.stall = 1'b0;
      q.push_back(e);
    end else if (st != c_ST_NONE) begin
      for (int k = 0; k < sz; k++) begin
        e = '0;
        e.st = c_ST_SB; e.addr = a + 32'(k); e.data = {24'd0, d[8*k +: 8]};
        e.mask = 32'hFF; e.stall = (k < sz - 1);
        q.push_back(e);
      end
    end else begin
      base = {a[31:2], 2'b00};
      e.ld = c_LD_LW; e.addr = base; e.stall = 1'b1;
      q.push_back(e);
      e.addr = base + 32'd4; e.wr = wr; e.chk_dst = 1'b1; e.dst = dst;
      e.stall = 1'b0; e.is_hi = 1'b1;
      q.push_back(e);
      v = '0;
      for (int k = 0; k < sz; k++) v = v | (32'(byte_at(a + 32'(k))) << (8 * k));
      if (lde == c_LD_LH && v[15]) v = v | 32'hFFFF0000;
      mq.push_back(v);
    end
  endtask

  task automatic drive(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] a,
                       input logic [31:0] d, input logic wr, input logic [4:0] dst);
    info_load = ld; info_store = st; alu_result = a; rs2 = d; write_reg = wr; dst_addr = dst;
  endtask

  task automatic do_access(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] a,
                           input logic [31:0] d, input logic wr, input logic [4:0] dst);
    int cyc;
    push_access(ld, st, a, d, wr, dst);
    drive(ld, st, a, d, wr, dst);
    cyc = 0;
    while (1) begin
      @(negedge clk);
      if (!stall) break;
      cyc++;
      if (cyc > 6) begin
        n_chk++; n_fail++;
        $display("FAIL stall_timeout: stall still %b after %0d cycles, expected 0", stall, cyc);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    drive(c_LD_NONE, c_ST_NONE, 32'd0, 32'd0, 1'b0, 5'd0);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compares every issued access and every merge pulse.
  initial begin
    exp_t        e;
    logic        exp_merge;
    logic [31:0] v;
    exp_merge = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstd) begin
        exp_merge = 1'b0;
        continue;
      end
      chk("merge_sel", {31'd0, merge_sel}, {31'd0, exp_merge});
      if (exp_merge) begin
        if (mq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL merge_data: got %h expected nothing queued", merge_data);
        end else begin
          v = mq.pop_front();
          chk("merge_data", merge_data, v);
        end
      end
      exp_merge = 1'b0;
      if (info_load_o != c_LD_NONE || info_store_o != c_ST_NONE) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_access: got ld=%0d st=%0d addr=%h expected no access",
                   info_load_o, info_store_o, alu_result_o);
        end else begin
          e = q.pop_front();
          if (info_load_o !== e.ld || info_store_o !== e.st || alu_result_o !== e.addr ||
              ((rs2_o ^ e.data) & e.mask) !== 32'd0 || write_reg_o !== e.wr ||
              (e.chk_dst && dst_addr_o !== e.dst) || stall !== e.stall) begin
            n_fail++;
            $display("FAIL access: got ld=%0d st=%0d addr=%h data=%h wr=%b dst=%0d stall=%b expected ld=%0d st=%0d addr=%h data=%h/%h wr=%b dst=%0d stall=%b",
                     info_load_o, info_store_o, alu_result_o, rs2_o, write_reg_o, dst_addr_o, stall,
                     e.ld, e.st, e.addr, e.data, e.mask, e.wr, e.dst, e.stall);
          end
          exp_merge = e.is_hi;
        end
      end else if (q.size() != 0) begin
        n_chk++; n_fail++;
        e = q.pop_front();
        $display("FAIL missing_access: got none expected ld=%0d st=%0d addr=%h", e.ld, e.st, e.addr);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  st;
    logic [2:0]  ld;
    logic [31:0] a;
    // Misaligned store presented during reset must not leak onto the issue port.
    drive(c_LD_NONE, c_ST_SW, 32'h101, 32'h12345678, 1'b1, 5'd3);
    repeat (2) @(posedge clk);
    #2;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_write_reg_o", {31'd0, write_reg_o}, 32'd0);
    chk("rst_info_store_o", {30'd0, info_store_o}, {30'd0, c_ST_NONE});
    chk("rst_info_load_o", {29'd0, info_load_o}, {29'd0, c_LD_NONE});
    chk("rst_merge_sel", {31'd0, merge_sel}, 32'd0);
    chk("rst_merge_data", merge_data, 32'd0);
    idle(1);
    rstd = 1'b1;
    idle(1);

    do_access(c_LD_NONE, c_ST_SW, 32'h100, 32'hDEADBEEF, 1'b0, 5'd0);
    idle(2);
    do_access(c_LD_NONE, c_ST_SW, 32'h101, 32'h44332211, 1'b0, 5'd0);
    idle(1);
    ovr_a0 = 32'h200; ovr_d0 = 32'h80123456;
    ovr_a1 = 32'h204; ovr_d1 = 32'hABCDEF7F;
    do_access(c_LD_LH, c_ST_NONE, 32'h203, 32'd0, 1'b1, 5'd7);
    idle(2);
    ovr_a0 = 32'hFFFFFFFC; ovr_d0 = 32'hBBAA0000;
    ovr_a1 = 32'h0;        ovr_d1 = 32'h0000DDCC;
    do_access(c_LD_LW, c_ST_NONE, 32'hFFFFFFFE, 32'd0, 1'b1, 5'd9);
    idle(2);
    chk("wrap_merge_value", merge_data, 32'hDDCCBBAA);
    do_access(c_LD_LHU, c_ST_NONE, 32'h003, 32'd0, 1'b1, 5'd4);
    do_access(c_LD_NONE, c_ST_SH, 32'h007, 32'h0000BEEF, 1'b0, 5'd0);
    do_access(c_LD_LW, c_ST_SB, 32'h011, 32'h000000AA, 1'b1, 5'd2);
    idle(2);

    // Reset during the byte-2 cycle of a split word store.
    push_access(c_LD_NONE, c_ST_SW, 32'h301, 32'h44332211, 1'b0, 5'd0);
    drive(c_LD_NONE, c_ST_SW, 32'h301, 32'h44332211, 1'b0, 5'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstd = 1'b0;
    #1;
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    chk("midrst_info_store_o", {30'd0, info_store_o}, {30'd0, c_ST_NONE});
    chk("midrst_write_reg_o", {31'd0, write_reg_o}, 32'd0);
    chk("midrst_merge_data", merge_data, 32'd0);
    chk("midrst_bytes_left", 32'(q.size()), 32'd2);
    q.delete();
    drive(c_LD_NONE, c_ST_NONE, 32'd0, 32'd0, 1'b0, 5'd0);
    repeat (2) @(posedge clk);
    #1 rstd = 1'b1;
    idle(3);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        idle(1);
      end else begin
        case ($urandom_range(0, 3))
          0:       a = $urandom;
          1:       a = 32'hFFFFFFF0 | ($urandom & 32'hF);
          default: a = $urandom & 32'h3FF;
        endcase
        st = ($urandom_range(0, 1) == 0) ? c_ST_NONE : 2'($urandom_range(0, 3));
        ld = 3'($urandom_range(0, 5));
        do_access(ld, st, a, $urandom, 1'($urandom), 5'($urandom));
      end
    end
    idle(4);
    chk("queue_empty", 32'(q.size()), 32'd0);
    chk("merge_queue_empty", 32'(mq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
